// File: rtl/cus19_alu_pkg.sv
// Shared opcode encodings, FSM state type and result-width helper for the
// cus19 ALU sequencer and its iterative multiply/divide datapath.
package cus19_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_MUL = 4'b0110;
  localparam logic [3:0] OP_DIV = 4'b0111;
  localparam logic [3:0] OP_INC = 4'b1000;
  localparam logic [3:0] OP_DEC = 4'b1001;
  localparam logic [3:0] OP_AND = 4'b1010;
  localparam logic [3:0] OP_OR  = 4'b1011;
  localparam logic [3:0] OP_XOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  function automatic int res_w(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/cus19_muldiv_iter.sv
// Shared shift/accumulate datapath for unsigned shift-add MUL and restoring DIV.
// The divide path exists only when CUS19_ALU_DIV_EN is defined.
module cus19_muldiv_iter
  import cus19_alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       is_div,
  input  logic [DATA_W-1:0]          a,
  input  logic [DATA_W-1:0]          b,
  output logic                       last,
  output logic [res_w(DATA_W)-1:0]   res_next
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] dsr;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc_n;
  logic [DATA_W-1:0] q_n;
  logic [DATA_W:0]   sum;

`ifdef CUS19_ALU_DIV_EN
  logic            div_mode;
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;
`else
  logic unused_div;
  assign unused_div = is_div;
`endif

  // MUL: {acc,q} shifts right, q[0] selects whether the multiplicand is added.
  // DIV: {acc,q} shifts left, acc holds the partial remainder.
  always_comb begin
    sum   = {1'b0, acc} + {1'b0, (q[0] ? dsr : '0)};
    acc_n = sum[DATA_W:1];
    q_n   = {sum[0], q[DATA_W-1:1]};
`ifdef CUS19_ALU_DIV_EN
    shifted = {acc, q[DATA_W-1]};
    diff    = shifted - {1'b0, dsr};
    if (div_mode) begin
      if (!diff[DATA_W]) begin
        acc_n = diff[DATA_W-1:0];
        q_n   = {q[DATA_W-2:0], 1'b1};
      end else begin
        acc_n = shifted[DATA_W-1:0];
        q_n   = {q[DATA_W-2:0], 1'b0};
      end
    end
`endif
  end

  assign last     = (cnt == CNT_W'(1));
  assign res_next = {acc_n, q_n};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      q   <= '0;
      dsr <= '0;
      cnt <= '0;
`ifdef CUS19_ALU_DIV_EN
      div_mode <= 1'b0;
`endif
    end else if (start) begin
      acc <= '0;
      q   <= a;
      dsr <= b;
      cnt <= CNT_W'(DATA_W);
`ifdef CUS19_ALU_DIV_EN
      div_mode <= is_div;
`endif
    end else if (cnt != '0) begin
      acc <= acc_n;
      q   <= q_n;
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/cus19_alu_seq_unit.sv
// ALU sequencer: request/response handshake, single-cycle ops and MUL/DIV sequencing.
// Define CUS19_ALU_DIV_EN to build the iterative divider; otherwise DIV is illegal.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | MUL/DIV iterating in cus19_muldiv_iter
// DONE  | result valid, waiting for out_ready
module cus19_alu_seq_unit
  import cus19_alu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 4
) (
  input  logic                       cus19_clk_in,
  input  logic                       cus19_rst_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_op,
  input  logic [DATA_W-1:0]          in_a,
  input  logic [DATA_W-1:0]          in_b,
  input  logic [REG_ADDR_W-1:0]      in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [res_w(DATA_W)-1:0]   out_result,
  output logic [REG_ADDR_W-1:0]      out_tag,
  output logic                       out_err,
  output logic                       busy
);

  localparam int RES_W = res_w(DATA_W);

  alu_state_t       state;
  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;
  logic [RES_W-1:0] sc_res;
  logic             sc_err;
  logic             need_iter;
  logic             div_sel;
  logic             iter_start;
  logic             iter_last;
  logic [RES_W-1:0] iter_res;

  assign a_ext = RES_W'(in_a);
  assign b_ext = RES_W'(in_b);

  // SUB/DEC use full-width arithmetic so a borrow sign-extends the result.
  always_comb begin
    sc_res    = '0;
    sc_err    = 1'b0;
    need_iter = 1'b0;
    div_sel   = 1'b0;
    case (in_op)
      OP_ADD: sc_res = a_ext + b_ext;
      OP_SUB: sc_res = a_ext - b_ext;
      OP_MUL: need_iter = 1'b1;
      OP_DIV: begin
`ifdef CUS19_ALU_DIV_EN
        if (in_b == '0) begin
          sc_res = {in_a, {DATA_W{1'b1}}};
          sc_err = 1'b1;
        end else begin
          need_iter = 1'b1;
          div_sel   = 1'b1;
        end
`else
        sc_err = 1'b1;
`endif
      end
      OP_INC: sc_res = a_ext + RES_W'(1);
      OP_DEC: sc_res = a_ext - RES_W'(1);
      OP_AND: sc_res = a_ext & b_ext;
      OP_OR:  sc_res = a_ext | b_ext;
      OP_XOR: sc_res = a_ext ^ b_ext;
      default: sc_err = 1'b1;
    endcase
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign iter_start = (state == IDLE) && in_valid && need_iter;

  cus19_muldiv_iter #(
    .DATA_W (DATA_W)
  ) u_muldiv (
    .clk      (cus19_clk_in),
    .rst      (cus19_rst_in),
    .start    (iter_start),
    .is_div   (div_sel),
    .a        (in_a),
    .b        (in_b),
    .last     (iter_last),
    .res_next (iter_res)
  );

  always_ff @(posedge cus19_clk_in or posedge cus19_rst_in) begin
    if (cus19_rst_in) begin
      state      <= IDLE;
      out_result <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_tag <= in_tag;
            if (need_iter) begin
              out_result <= '0;
              out_err    <= 1'b0;
              state      <= CALC;
            end else begin
              out_result <= sc_res;
              out_err    <= sc_err;
              state      <= DONE;
            end
          end
        end
        CALC: begin
          if (iter_last) begin
            out_result <= iter_res;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cus19_alu_seq_unit.sv
// Self-checking bench for cus19_alu_seq_unit: arithmetic reference model plus
// per-cycle compare process, with directed vectors and literal pins.
module tb_cus19_alu_seq_unit;

  localparam int W  = 8;
  localparam int TW = 4;
  localparam int M  = 1 << (2 * W);
`ifdef CUS19_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_op = 4'h0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*W-1:0] out_result;
  logic [TW-1:0] out_tag;
  logic          out_err;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int last_res, last_lat, last_tag;
  bit last_err;

  typedef struct {
    int res;
    bit err;
    int lat;
    int tag;
    int acc;
  } exp_t;
  exp_t expq[$];

  cus19_alu_seq_unit #(.DATA_W(W), .REG_ADDR_W(TW)) dut (
    .cus19_clk_in (clk),
    .cus19_rst_in (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_tag      (out_tag),
    .out_err      (out_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void model(input logic [3:0] op, input int a, input int b,
                                output int res, output bit err, output int lat);
    res = 0; err = 1'b0; lat = 1;
    case (op)
      4'h4: res = (a + b) % M;
      4'h5: res = (a - b + M) % M;
      4'h6: begin res = a * b; lat = W + 1; end
      4'h7: begin
        if (!DIV_EN) err = 1'b1;
        else if (b == 0) begin res = a * (1 << W) + (1 << W) - 1; err = 1'b1; end
        else begin res = (a % b) * (1 << W) + a / b; lat = W + 1; end
      end
      4'h8: res = a + 1;
      4'h9: res = (a - 1 + M) % M;
      4'hA: res = a & b;
      4'hB: res = a | b;
      4'hC: res = a ^ b;
      default: err = 1'b1;
    endcase
  endfunction

  // Per-cycle comparison against the pending-transaction model.
  always @(negedge clk) begin
    exp_t e;
    bit pend;
    if (rst) begin
      expq.delete();
    end else begin
      pend = (expq.size() != 0);
      chk("busy", busy, pend);
      chk("in_ready", in_ready, !pend);
      if (pend) begin
        e = expq[0];
        chk("out_valid_timing", out_valid, (cyc - e.acc) >= e.lat);
        if (out_valid) begin
          chk("out_result", out_result, e.res);
          chk("out_err", out_err, e.err);
          chk("out_tag", out_tag, e.tag);
          if (out_ready) begin
            last_res = out_result;
            last_err = out_err;
            last_tag = out_tag;
            last_lat = cyc - e.acc;
            void'(expq.pop_front());
            pop_cnt++;
          end
        end
      end else begin
        chk("out_valid_idle", out_valid, 1'b0);
      end
      if (in_valid && in_ready) begin
        model(in_op, int'(in_a), int'(in_b), e.res, e.err, e.lat);
        e.tag = int'(in_tag);
        e.acc = cyc;
        expq.push_back(e);
      end
    end
  end

  task automatic do_op(input logic [3:0] op, input int a, input int b, input int tag);
    int n;
    int p0;
    p0 = pop_cnt;
    in_op = op; in_a = a[W-1:0]; in_b = b[W-1:0]; in_tag = tag[TW-1:0]; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_wait", n < 50, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_a = 8'h5A; in_b = 8'hC3; in_op = 4'h0; in_tag = '1;
    n = 0;
    while (pop_cnt == p0 && n < 100) begin @(posedge clk); n++; end
    chk("result_wait", pop_cnt != p0, 1'b1);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_result"}, out_result, 0);
    chk({tag, "_out_tag"}, out_tag, 0);
    chk({tag, "_out_err"}, out_err, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;

    do_op(4'h4, 10, 20, 5);
    chk("add_res", last_res, 30); chk("add_err", last_err, 0);
    chk("add_lat", last_lat, 1);  chk("add_tag", last_tag, 5);

    do_op(4'h6, 10, 20, 2);
    chk("mul_res", last_res, 200); chk("mul_lat", last_lat, 9);
    do_op(4'h6, 255, 255, 9);
    chk("mul_max_res", last_res, 65025); chk("mul_max_lat", last_lat, 9);

    do_op(4'h7, 20, 10, 1);
    chk("div_20_10_res", last_res, DIV_EN ? 32'h0002 : 32'h0);
    chk("div_20_10_err", last_err, !DIV_EN);
    chk("div_20_10_lat", last_lat, DIV_EN ? 9 : 1);
    do_op(4'h7, 23, 5, 4);
    chk("div_23_5_res", last_res, DIV_EN ? 32'h0304 : 32'h0);
    do_op(4'h7, 7, 0, 6);
    chk("div_by0_res", last_res, DIV_EN ? 32'h07FF : 32'h0);
    chk("div_by0_err", last_err, 1'b1); chk("div_by0_lat", last_lat, 1);

    do_op(4'h5, 10, 20, 3);
    chk("sub_neg_res", last_res, 32'hFFF6);
    do_op(4'h5, 50, 7, 3);
    chk("sub_pos_res", last_res, 43);
    do_op(4'h9, 0, 99, 8);
    chk("dec_zero_res", last_res, 32'hFFFF);
    do_op(4'h8, 255, 0, 8);
    chk("inc_carry_res", last_res, 32'h0100);
    do_op(4'h4, 200, 100, 10);
    chk("add_carry_res", last_res, 300);
    do_op(4'hA, 8'hF0, 8'h3C, 11);
    chk("and_res", last_res, 32'h30);
    do_op(4'hB, 8'hF0, 8'h0C, 12);
    chk("or_res", last_res, 32'hFC);
    do_op(4'hF, 1, 2, 13);
    chk("illegal_f_res", last_res, 0); chk("illegal_f_err", last_err, 1);
    do_op(4'h0, 1, 2, 14);
    chk("illegal_0_err", last_err, 1); chk("illegal_0_lat", last_lat, 1);

    // Backpressure: hold the XOR result for three cycles.
    out_ready = 1'b0;
    in_op = 4'hC; in_a = 8'd10; in_b = 8'd20; in_tag = 4'd3; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_accept_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0; in_a = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_hold_res", out_result, 30);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_ready", in_ready, 1'b1);
    chk("bp_idle_busy", busy, 1'b0);
    chk("bp_last_res", last_res, 30);
    @(posedge clk);
    #1;

    // Reset in the middle of a multiply.
    in_op = 4'h6; in_a = 8'd10; in_b = 8'd20; in_tag = 4'd9; in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("mid_mul_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk_reset_vals("mid_mul_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    do_op(4'h4, 1, 1, 7);
    chk("post_rst_add_res", last_res, 2);
    chk("post_rst_add_lat", last_lat, 1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
